td4_sw_rom: RTL and testbench
=============================

Name: td4_sw_rom

Overview:
- 16-word x 8-bit "switch ROM" for the TD4 CPU: program memory built from DIP-switch inputs.
- Each word is supplied externally on its own 8-bit port (mem0..memF).
- 4-bit address A selects one word onto Q combinationally. This is the instruction-fetch path driven by the program counter.
- A registered copy (Q_r) is provided for synchronous consumers and debug.

Parameters:
- None. Depth is fixed at 16 words and width at 8 bits.

Ports:
- clk  input  1  system clock; rising edge active.
- rst  input  1  synchronous, active-high reset.
- A  input  4  word address.
- mem0 .. memF  input  8 each  switch contents of words 0x0..0xF (16 ports).
- Q  output  8  selected word, combinational.
- Q_r  output  8  selected word, registered.

Behaviour:
- Q = memN where N = A (A=0 -> mem0, ..., A=0xA -> memA, ..., A=0xF -> memF).
- Q is purely combinational with zero latency:
  - a change on A, or on the currently selected memN, appears on Q in the same timestep;
  - no clock edge is required.
- Q does not depend on clk or rst. rst never forces Q.
- Full decode: all 16 addresses are valid. No out-of-range case, no wrap logic needed; A=0xF+1 wrapping to 0x0 is the driver's concern.
- X/Z on any bit of A: Q is don't-care in simulation. Synthesis uses a plain 16:1 mux (case with a default of 8'h00).
- Q_r register:
  - on each rising clk edge, if rst=1 then Q_r <= 8'h00; otherwise Q_r <= Q;
  - one-cycle latency from A/mem to Q_r;
  - Q_r is 8'h00 from the first reset edge until the first non-reset edge.
- Reset asserted mid-operation: Q_r clears on the next edge and Q keeps tracking A. After rst deasserts, Q_r resumes capturing Q on the following edge.
- mem inputs are treated as static switches. No synchronizers are required. The integrator must not toggle them asynchronously relative to clk if Q_r is used.
- No internal storage other than Q_r. No write port.

Test Plan:
- Address sweep:
  - stimulus: memN = 8'h0N for all N; A starts at 4'h0 and increments every 10 time units for 200 units;
  - required: Q equals A zero-extended at every step (00,01,...,0F), then 00 again after A wraps 0xF -> 0x0.
- Distinct patterns:
  - stimulus: mem0=8'hA5, mem7=8'h3C, memF=8'hFF, all other words 8'h00;
  - required: A=0 -> Q=A5, A=7 -> Q=3C, A=F -> Q=FF, A=1 -> Q=00.
- Live switch change:
  - stimulus: hold A=4'h5, change mem5 from 8'h12 to 8'h34;
  - required: Q becomes 34 in the same timestep, with no clock needed.
  - stimulus: change mem6 instead;
  - required: Q is unchanged.
- Registered path:
  - stimulus: rst=0, A=3 then A=9 on successive cycles, with mem3=8'h33 and mem9=8'h99;
  - required: Q_r shows 33 then 99, each one clock after the address is applied.
- Reset:
  - stimulus: assert rst for 2 clk cycles while A=0xC and memC=8'hCC;
  - required: Q_r=00 after the first edge, Q=CC throughout; Q_r=CC on the first edge after rst deasserts.

Source files
------------

// File: rtl/td4_sw_rom.sv
// Switch-programmed 16x8 instruction ROM for the TD4 CPU.
// Q is a zero-latency mux of the switch words; Q_r is a registered copy of Q.
module td4_sw_rom (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [7:0] mem0,
    input  logic [7:0] mem1,
    input  logic [7:0] mem2,
    input  logic [7:0] mem3,
    input  logic [7:0] mem4,
    input  logic [7:0] mem5,
    input  logic [7:0] mem6,
    input  logic [7:0] mem7,
    input  logic [7:0] mem8,
    input  logic [7:0] mem9,
    input  logic [7:0] memA,
    input  logic [7:0] memB,
    input  logic [7:0] memC,
    input  logic [7:0] memD,
    input  logic [7:0] memE,
    input  logic [7:0] memF,
    output logic [7:0] Q,
    output logic [7:0] Q_r
);

    logic [7:0] w_q;
    logic [7:0] r_q;

    // Fetch path: no clock or reset involvement, so PC changes show up immediately.
    always_comb begin
        w_q = 8'h00;
        case (A)
            4'h0:    w_q = mem0;
            4'h1:    w_q = mem1;
            4'h2:    w_q = mem2;
            4'h3:    w_q = mem3;
            4'h4:    w_q = mem4;
            4'h5:    w_q = mem5;
            4'h6:    w_q = mem6;
            4'h7:    w_q = mem7;
            4'h8:    w_q = mem8;
            4'h9:    w_q = mem9;
            4'hA:    w_q = memA;
            4'hB:    w_q = memB;
            4'hC:    w_q = memC;
            4'hD:    w_q = memD;
            4'hE:    w_q = memE;
            4'hF:    w_q = memF;
            default: w_q = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 8'h00;
        end else begin
            r_q <= w_q;
        end
    end

    assign Q   = w_q;
    assign Q_r = r_q;

endmodule

// File: tb/tb_td4_sw_rom.sv
// Directed self-checking bench for td4_sw_rom: combinational fetch and registered copy.
module tb_td4_sw_rom;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [7:0] mem [16];
    logic [7:0] Q;
    logic [7:0] Q_r;

    int n_checks = 0;
    int n_fail   = 0;

    td4_sw_rom dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .mem0 (mem[0]),
        .mem1 (mem[1]),
        .mem2 (mem[2]),
        .mem3 (mem[3]),
        .mem4 (mem[4]),
        .mem5 (mem[5]),
        .mem6 (mem[6]),
        .mem7 (mem[7]),
        .mem8 (mem[8]),
        .mem9 (mem[9]),
        .memA (mem[10]),
        .memB (mem[11]),
        .memC (mem[12]),
        .memD (mem[13]),
        .memE (mem[14]),
        .memF (mem[15]),
        .Q    (Q),
        .Q_r  (Q_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        logic [7:0] e;
        rst = 1'b1;
        A   = 4'h0;
        for (int n = 0; n < 16; n++) mem[n] = 8'(n);

        // Reset state of the register
        @(posedge clk); #1;
        chk("reset_qr", Q_r, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Address sweep with wrap from F back to 0
        for (int i = 0; i < 20; i++) begin
            A = 4'(i);
            #1;
            e = 8'(i % 16);
            chk("sweep_q", Q, e);
            #9;
        end

        // Distinct patterns
        for (int n = 0; n < 16; n++) mem[n] = 8'h00;
        mem[0]  = 8'hA5;
        mem[7]  = 8'h3C;
        mem[15] = 8'hFF;
        A = 4'h0; #1; chk("pat_a0", Q, 8'hA5);
        A = 4'h7; #1; chk("pat_a7", Q, 8'h3C);
        A = 4'hF; #1; chk("pat_aF", Q, 8'hFF);
        A = 4'h1; #1; chk("pat_a1", Q, 8'h00);

        // Live switch change with no clock edge in between
        @(negedge clk);
        A = 4'h5;
        mem[5] = 8'h12;
        #1; chk("live_before", Q, 8'h12);
        mem[5] = 8'h34;
        #1; chk("live_sel", Q, 8'h34);
        mem[6] = 8'h77;
        #1; chk("live_other", Q, 8'h34);

        // Registered path: one cycle latency
        @(negedge clk);
        mem[3] = 8'h33;
        mem[9] = 8'h99;
        A = 4'h3;
        @(posedge clk); #1;
        chk("reg_33", Q_r, 8'h33);
        A = 4'h9;
        #1; chk("reg_hold", Q_r, 8'h33);
        chk("reg_q99", Q, 8'h99);
        @(posedge clk); #1;
        chk("reg_99", Q_r, 8'h99);

        // Reset mid-operation: Q keeps tracking, Q_r clears then resumes
        @(negedge clk);
        mem[12] = 8'hCC;
        A   = 4'hC;
        rst = 1'b1;
        #1; chk("rst_q_pre", Q, 8'hCC);
        @(posedge clk); #1;
        chk("rst_qr_1", Q_r, 8'h00);
        chk("rst_q_1", Q, 8'hCC);
        @(posedge clk); #1;
        chk("rst_qr_2", Q_r, 8'h00);
        chk("rst_q_2", Q, 8'hCC);
        @(negedge clk);
        rst = 1'b0;
        #1; chk("rst_qr_rel", Q_r, 8'h00);
        @(posedge clk); #1;
        chk("rst_qr_cc", Q_r, 8'hCC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
